// File: rtl/cntr_pkg.sv
// Shared definitions for the cntr_n counter family: state width and state encodings.
package cntr_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] S_IDLE = 3'b000;
    localparam logic [STATE_W-1:0] S_LOAD = 3'b001;
    localparam logic [STATE_W-1:0] S_INC  = 3'b010;
    localparam logic [STATE_W-1:0] S_INC2 = 3'b011;
    localparam logic [STATE_W-1:0] S_DEC  = 3'b100;
    localparam logic [STATE_W-1:0] S_DEC2 = 3'b101;

endpackage

// File: rtl/cntr_n_ns.sv
// Combinational next-state logic for cntr_n: load beats everything, opposing requests cancel,
// and a repeated request in the same direction promotes to the double-step state.
module cntr_n_ns
    import cntr_pkg::*;
(
    input  logic [STATE_W-1:0] state,
    input  logic               inc,
    input  logic               dec,
    input  logic               load,
    output logic [STATE_W-1:0] next_state
);

    logic state_legal;

    assign state_legal = (state != 3'b110) && (state != 3'b111);

    always_comb begin
        next_state = S_IDLE;
        // An unused encoding always falls back to IDLE, whatever the inputs request.
        if (!state_legal) begin
            next_state = S_IDLE;
        end else if (load) begin
            next_state = S_LOAD;
        end else if (inc && dec) begin
            next_state = S_IDLE;
        end else if (inc) begin
            next_state = (state == S_INC || state == S_INC2) ? S_INC2 : S_INC;
        end else if (dec) begin
            next_state = (state == S_DEC || state == S_DEC2) ? S_DEC2 : S_DEC;
        end
    end

endmodule

// File: rtl/cntr_n.sv
// Up/down counter with parallel load, accelerated stepping and wrap or clamp on overflow.
// The value is updated at the same edge the new state is entered.
module cntr_n
    import cntr_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inc,
    input  logic               dec,
    input  logic               load,
    input  logic [WIDTH-1:0]   d_in,
    output logic [WIDTH-1:0]   d_out,
    output logic [STATE_W-1:0] o_state,
    output logic               o_tc
);

    localparam logic [WIDTH:0] STEP1 = (WIDTH+1)'(1);
    localparam logic [WIDTH:0] STEP2 = (WIDTH+1)'(2);

    logic [STATE_W-1:0] state_reg, state_next;
    logic [WIDTH-1:0]   cnt_reg, cnt_next;
    logic               tc_reg, tc_next;
    logic [WIDTH:0]     cnt_ext;
    logic [WIDTH:0]     sum;
    logic               going_up;

    cntr_n_ns u_ns (
        .state      (state_reg),
        .inc        (inc),
        .dec        (dec),
        .load       (load),
        .next_state (state_next)
    );

    assign cnt_ext = {1'b0, cnt_reg};

    always_comb begin
        sum      = cnt_ext;
        going_up = 1'b0;
        case (state_next)
            S_INC:   begin sum = cnt_ext + STEP1; going_up = 1'b1; end
            S_INC2:  begin sum = cnt_ext + STEP2; going_up = 1'b1; end
            S_DEC:   sum = cnt_ext - STEP1;
            S_DEC2:  sum = cnt_ext - STEP2;
            default: sum = cnt_ext;
        endcase
    end

    // The extra top bit is a carry when stepping up and a borrow when stepping down.
    always_comb begin
        cnt_next = cnt_reg;
        tc_next  = 1'b0;
        if (state_next == S_LOAD) begin
            cnt_next = d_in;
        end else if (sum[WIDTH]) begin
            tc_next = 1'b1;
            if (SATURATE) begin
                cnt_next = going_up ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
            end else begin
                cnt_next = sum[WIDTH-1:0];
            end
        end else begin
            cnt_next = sum[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            tc_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            tc_reg    <= tc_next;
        end
    end

    assign d_out   = cnt_reg;
    assign o_state = state_reg;
    assign o_tc    = tc_reg;

endmodule
